// File: rtl/sdot_dma_master.sv
// sdot_dma_master: CSR-programmed DMA master that streams an x vector and a
// w vector into a dot-product accelerator, reads back its result and stores
// it to a destination address. Single outstanding transfer at a time.
module sdot_dma_master #(
  parameter logic [31:0] ACC_BASE = 32'h0000_0000,
  parameter logic [31:0] RES_ADDR = 32'h0000_1000,
  parameter int unsigned MAX_LEN  = 96
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [2:0]  csr_address,
  input  logic        csr_write,
  input  logic        csr_read,
  input  logic        csr_chipselect,
  input  logic [31:0] csr_writedata,
  output logic [31:0] csr_readdata,
  output logic [31:0] m_address,
  output logic        m_read,
  output logic        m_write,
  output logic [31:0] m_writedata,
  input  logic [31:0] m_readdata,
  input  logic        m_waitrequest,
  output logic        irq
);

  localparam logic [6:0] LP_MAX_LEN = 7'(MAX_LEN);

  typedef enum logic [2:0] {
    S_IDLE, S_RD_X, S_WR_X, S_RD_W, S_WR_W, S_RD_RES, S_WR_RES, S_FIN
  } state_t;

  state_t      r_state;
  logic        r_busy;
  logic        r_done;
  logic [31:0] r_src_x;
  logic [31:0] r_src_w;
  logic [31:0] r_dst;
  logic [6:0]  r_len;
  logic [6:0]  r_len_eff;
  logic [6:0]  r_i;
  logic [31:0] r_result;
  logic [31:0] r_data;
  logic [31:0] r_m_address;
  logic        r_m_read;
  logic        r_m_write;
  logic [31:0] r_csr_readdata;

  logic        w_start;
  logic [6:0]  w_len_eff;
  logic [6:0]  w_i_next;
  logic        w_more;
  logic [31:0] w_off;
  logic [31:0] w_off_next;

  assign w_start    = csr_chipselect & csr_write & (csr_address == 3'd0) & csr_writedata[0];
  assign w_len_eff  = (r_len > LP_MAX_LEN) ? LP_MAX_LEN : r_len;
  assign w_i_next   = r_i + 7'd1;
  assign w_more     = ({1'b0, r_i} + 8'd1) < {1'b0, r_len_eff};
  assign w_off      = {23'd0, r_i, 2'b00};
  assign w_off_next = {23'd0, w_i_next, 2'b00};

  // Job configuration registers; frozen while a job is running.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_src_x <= '0;
      r_src_w <= '0;
      r_dst   <= '0;
      r_len   <= '0;
    end else if (csr_chipselect && csr_write && !r_busy) begin
      case (csr_address)
        3'd2:    r_src_x <= csr_writedata;
        3'd3:    r_src_w <= csr_writedata;
        3'd4:    r_len   <= csr_writedata[6:0];
        3'd5:    r_dst   <= csr_writedata;
        default: ;
      endcase
    end
  end

  // Transfer sequencer; master strobes/address/data are registered and
  // loaded on the transition into each transfer state so the strobe is up
  // in the first cycle of that state and holds until accepted.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= S_IDLE;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_m_read    <= 1'b0;
      r_m_write   <= 1'b0;
      r_m_address <= '0;
      r_data      <= '0;
      r_result    <= '0;
      r_i         <= '0;
      r_len_eff   <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_start) begin
            r_done    <= 1'b0;
            r_busy    <= 1'b1;
            r_i       <= '0;
            r_len_eff <= w_len_eff;
            if (w_len_eff != 7'd0) begin
              r_m_read    <= 1'b1;
              r_m_address <= r_src_x;
              r_state     <= S_RD_X;
            end else begin
              r_state <= S_FIN;
            end
          end
        end
        S_RD_X: begin
          if (!m_waitrequest) begin
            r_data      <= m_readdata;
            r_m_read    <= 1'b0;
            r_m_write   <= 1'b1;
            r_m_address <= ACC_BASE + 32'h80 + w_off;
            r_state     <= S_WR_X;
          end
        end
        S_WR_X: begin
          if (!m_waitrequest) begin
            r_m_write <= 1'b0;
            r_m_read  <= 1'b1;
            if (w_more) begin
              r_i         <= w_i_next;
              r_m_address <= r_src_x + w_off_next;
              r_state     <= S_RD_X;
            end else begin
              r_i         <= '0;
              r_m_address <= r_src_w;
              r_state     <= S_RD_W;
            end
          end
        end
        S_RD_W: begin
          if (!m_waitrequest) begin
            r_data      <= m_readdata;
            r_m_read    <= 1'b0;
            r_m_write   <= 1'b1;
            r_m_address <= ACC_BASE + w_off;
            r_state     <= S_WR_W;
          end
        end
        S_WR_W: begin
          if (!m_waitrequest) begin
            r_m_write <= 1'b0;
            r_m_read  <= 1'b1;
            if (w_more) begin
              r_i         <= w_i_next;
              r_m_address <= r_src_w + w_off_next;
              r_state     <= S_RD_W;
            end else begin
              r_i         <= '0;
              r_m_address <= RES_ADDR;
              r_state     <= S_RD_RES;
            end
          end
        end
        S_RD_RES: begin
          if (!m_waitrequest) begin
            r_result    <= m_readdata;
            r_data      <= m_readdata;
            r_m_read    <= 1'b0;
            r_m_write   <= 1'b1;
            r_m_address <= r_dst;
            r_state     <= S_WR_RES;
          end
        end
        S_WR_RES: begin
          if (!m_waitrequest) begin
            r_m_write <= 1'b0;
            r_state   <= S_FIN;
          end
        end
        S_FIN: begin
          r_busy  <= 1'b0;
          r_done  <= 1'b1;
          r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // CSR read port, one cycle latency; returns values from before this edge.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_csr_readdata <= '0;
    end else if (csr_chipselect && csr_read) begin
      case (csr_address)
        3'd1:    r_csr_readdata <= {30'd0, r_done, r_busy};
        3'd2:    r_csr_readdata <= r_src_x;
        3'd3:    r_csr_readdata <= r_src_w;
        3'd4:    r_csr_readdata <= {25'd0, r_len};
        3'd5:    r_csr_readdata <= r_dst;
        3'd6:    r_csr_readdata <= r_result;
        default: r_csr_readdata <= '0;
      endcase
    end
  end

  assign csr_readdata = r_csr_readdata;
  assign m_address    = r_m_address;
  assign m_read       = r_m_read;
  assign m_write      = r_m_write;
  assign m_writedata  = r_data;
  assign irq          = r_done;

endmodule

// File: tb/tb_sdot_dma_master.sv
// Directed bench for sdot_dma_master: a table of jobs plus hand sequences
// for busy-time CSR activity and mid-job reset.
module tb_sdot_dma_master;

  localparam logic [31:0] ACC  = 32'h0000_0000;
  localparam logic [31:0] RES  = 32'h0000_1000;
  localparam logic [31:0] RVAL = 32'h40C0_0000;

  logic        clk = 1'b0;
  logic        reset;
  logic [2:0]  csr_address;
  logic        csr_write, csr_read, csr_chipselect;
  logic [31:0] csr_writedata, csr_readdata;
  logic [31:0] m_address, m_writedata, m_readdata;
  logic        m_read, m_write, m_waitrequest, irq;

  int unsigned n_vec = 0;
  int unsigned n_err = 0;
  int unsigned g_stall = 0;
  int unsigned r_cnt;

  logic [31:0] wr_addr_q[$];
  logic [31:0] wr_data_q[$];
  logic [31:0] rd_addr_q[$];

  sdot_dma_master #(.ACC_BASE(ACC), .RES_ADDR(RES), .MAX_LEN(96)) dut (
    .clk(clk), .reset(reset),
    .csr_address(csr_address), .csr_write(csr_write), .csr_read(csr_read),
    .csr_chipselect(csr_chipselect), .csr_writedata(csr_writedata),
    .csr_readdata(csr_readdata),
    .m_address(m_address), .m_read(m_read), .m_write(m_write),
    .m_writedata(m_writedata), .m_readdata(m_readdata),
    .m_waitrequest(m_waitrequest), .irq(irq)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] slave_data(input logic [31:0] a);
    case (a)
      32'h2000: return 32'h3F80_0000;
      32'h2004: return 32'h4000_0000;
      32'h2008: return 32'h4040_0000;
      32'h3000, 32'h3004, 32'h3008: return 32'h3F80_0000;
      RES:      return RVAL;
      default:  return a ^ 32'h5A5A_0000;
    endcase
  endfunction

  assign m_readdata    = slave_data(m_address);
  assign m_waitrequest = (m_read || m_write) && (r_cnt < g_stall);

  // Slave stall counter: each new strobe is held off g_stall cycles.
  always @(posedge clk) begin
    if (reset) r_cnt <= 0;
    else if (m_read || m_write) r_cnt <= m_waitrequest ? r_cnt + 1 : 0;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Bus monitor: logs accepted transfers, checks stall stability.
  logic        prev_stall;
  logic [65:0] saved;
  initial begin
    prev_stall = 1'b0;
    forever begin
      @(negedge clk);
      if (reset) begin
        prev_stall = 1'b0;
      end else begin
        if (prev_stall) begin
          n_vec++;
          if ({m_read, m_write, m_address, m_writedata} !== saved) begin
            n_err++;
            $display("FAIL stall_hold: got %h expected %h",
                     {m_read, m_write, m_address, m_writedata}, saved);
          end
        end
        if (m_read || m_write) begin
          n_vec++;
          if (m_read && m_write) begin
            n_err++;
            $display("FAIL one_strobe: got rd=%b wr=%b expected one", m_read, m_write);
          end
          if (!m_waitrequest) begin
            if (m_write) begin
              wr_addr_q.push_back(m_address);
              wr_data_q.push_back(m_writedata);
            end else begin
              rd_addr_q.push_back(m_address);
            end
          end
        end
        prev_stall = (m_read || m_write) && m_waitrequest;
        saved = {m_read, m_write, m_address, m_writedata};
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  task automatic csr_wr(input logic [2:0] a, input logic [31:0] d);
    @(negedge clk);
    csr_chipselect = 1'b1; csr_write = 1'b1; csr_address = a; csr_writedata = d;
    @(posedge clk); #1;
    csr_chipselect = 1'b0; csr_write = 1'b0;
  endtask

  task automatic csr_rd(input logic [2:0] a, output logic [31:0] d);
    @(negedge clk);
    csr_chipselect = 1'b1; csr_read = 1'b1; csr_address = a;
    @(posedge clk); #1;
    d = csr_readdata;
    csr_chipselect = 1'b0; csr_read = 1'b0;
  endtask

  typedef struct {
    logic [31:0] src_x;
    logic [31:0] src_w;
    logic [31:0] dst;
    logic [6:0]  len;
    int unsigned stall;
    int unsigned exp_l;
    int unsigned exp_cyc;
    logic [31:0] exp_res;
  } job_t;

  task automatic check_traffic(input job_t j);
    logic [31:0] ea[$];
    logic [31:0] ed[$];
    logic [31:0] er[$];
    int unsigned bad;
    for (int unsigned k = 0; k < j.exp_l; k++) begin
      er.push_back(j.src_x + 32'(4 * k));
      ea.push_back(ACC + 32'h80 + 32'(4 * k));
      ed.push_back(slave_data(j.src_x + 32'(4 * k)));
    end
    for (int unsigned k = 0; k < j.exp_l; k++) begin
      er.push_back(j.src_w + 32'(4 * k));
      ea.push_back(ACC + 32'(4 * k));
      ed.push_back(slave_data(j.src_w + 32'(4 * k)));
    end
    if (j.exp_l != 0) begin
      er.push_back(RES);
      ea.push_back(j.dst);
      ed.push_back(RVAL);
    end
    chk("wr_count", 32'(wr_addr_q.size()), 32'(ea.size()));
    chk("rd_count", 32'(rd_addr_q.size()), 32'(er.size()));
    bad = 0;
    for (int unsigned k = 0; k < ea.size() && k < wr_addr_q.size(); k++)
      if (wr_addr_q[k] !== ea[k] || wr_data_q[k] !== ed[k]) bad++;
    for (int unsigned k = 0; k < er.size() && k < rd_addr_q.size(); k++)
      if (rd_addr_q[k] !== er[k]) bad++;
    chk("seq_errors", bad, 0);
  endtask

  task automatic start_and_wait(output int unsigned cyc);
    csr_wr(3'd0, 32'h1);
    cyc = 0;
    while (!irq && cyc < 5000) begin
      @(posedge clk); #1;
      cyc++;
    end
  endtask

  task automatic run_job(input job_t j);
    int unsigned cyc;
    logic [31:0] d;
    csr_wr(3'd2, j.src_x);
    csr_wr(3'd3, j.src_w);
    csr_wr(3'd4, {25'd0, j.len});
    csr_wr(3'd5, j.dst);
    g_stall = j.stall;
    wr_addr_q.delete(); wr_data_q.delete(); rd_addr_q.delete();
    start_and_wait(cyc);
    chk("cycles", cyc, j.exp_cyc);
    chk("irq", {31'd0, irq}, 32'd1);
    csr_rd(3'd1, d); chk("status_done", d, 32'h2);
    csr_rd(3'd6, d); chk("result", d, j.exp_res);
    check_traffic(j);
  endtask

  job_t        jobs[6];
  logic [31:0] d;
  int unsigned cyc;

  initial begin
    jobs[0] = '{32'h2000, 32'h3000, 32'h4000, 7'd3, 0, 3, 15, RVAL};
    jobs[1] = '{32'h2000, 32'h3000, 32'h4000, 7'd3, 3, 3, 57, RVAL};
    jobs[2] = '{32'h2000, 32'h3000, 32'h4000, 7'd0, 0, 0, 1, RVAL};
    jobs[3] = '{32'hFFFF_FFFC, 32'h8000, 32'h4100, 7'd100, 0, 96, 387, RVAL};
    jobs[4] = '{32'h0100, 32'h0200, 32'h4200, 7'd1, 1, 1, 13, RVAL};
    jobs[5] = '{32'h5000, 32'h6000, 32'h4300, 7'd7, 2, 7, 91, RVAL};

    reset = 1'b1;
    csr_address = '0; csr_write = 1'b0; csr_read = 1'b0;
    csr_chipselect = 1'b0; csr_writedata = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_m_read", {31'd0, m_read}, 32'd0);
    chk("rst_m_write", {31'd0, m_write}, 32'd0);
    chk("rst_m_address", m_address, 32'd0);
    chk("rst_m_writedata", m_writedata, 32'd0);
    chk("rst_irq", {31'd0, irq}, 32'd0);
    chk("rst_readdata", csr_readdata, 32'd0);
    @(negedge clk); reset = 1'b0;
    for (int unsigned a = 0; a < 8; a++) begin
      csr_rd(3'(a), d);
      chk("rst_csr", d, 32'd0);
    end

    for (int unsigned k = 0; k < 6; k++) begin
      run_job(jobs[k]);
      if (jobs[k].src_x == 32'hFFFF_FFFC)
        chk("wrap_rd1", (rd_addr_q.size() > 1) ? rd_addr_q[1] : 32'hDEAD_BEEF, 32'h0);
    end

    // Start and SRC_X rewrite while busy must be ignored.
    csr_wr(3'd2, 32'h2000);
    csr_wr(3'd3, 32'h3000);
    csr_wr(3'd4, 32'd3);
    csr_wr(3'd5, 32'h4000);
    g_stall = 0;
    wr_addr_q.delete(); wr_data_q.delete(); rd_addr_q.delete();
    csr_wr(3'd0, 32'h1);
    csr_rd(3'd1, d); chk("busy_status", d, 32'h1);
    csr_wr(3'd2, 32'h9000);
    csr_wr(3'd0, 32'h1);
    cyc = 0;
    while (!irq && cyc < 5000) begin @(posedge clk); #1; cyc++; end
    chk("busy_irq", {31'd0, irq}, 32'd1);
    repeat (5) @(posedge clk);
    #1;
    chk("busy_idle_read", {31'd0, m_read}, 32'd0);
    csr_rd(3'd2, d); chk("busy_src_x", d, 32'h2000);
    check_traffic('{32'h2000, 32'h3000, 32'h4000, 7'd3, 0, 3, 15, RVAL});

    // Reset during WR_W with i=5 aborts; a new start runs the full job.
    csr_wr(3'd4, 32'd8);
    csr_wr(3'd0, 32'h1);
    cyc = 0;
    while (!(m_write && m_address == ACC + 32'h14) && cyc < 200) begin
      @(posedge clk); #1; cyc++;
    end
    chk("found_wr_w5", {31'd0, m_write && (m_address == ACC + 32'h14)}, 32'd1);
    reset = 1'b1;
    @(posedge clk); #1;
    chk("abort_m_write", {31'd0, m_write}, 32'd0);
    chk("abort_irq", {31'd0, irq}, 32'd0);
    reset = 1'b0;
    csr_rd(3'd1, d); chk("abort_status", d, 32'h0);
    run_job('{32'h2000, 32'h3000, 32'h4000, 7'd8, 0, 8, 35, RVAL});

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
